// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_ctrl arbiter: mem_ctrl op encodings, arbiter FSM states
// and the helper that decides which requester ops may be granted.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RELEASE
    } arb_state_t;

    // Only real transfers are granted; 00 and 10 never reach mem_ctrl.
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotate-priority picker: first eligible index after rr_ptr, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     win_idx,
    output logic               win_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_vld && eligible[idx]) begin
                winner[idx] = 1'b1;
                win_idx     = IDW'(idx);
                win_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one mem_ctrl among NUM_REQ requesters; MEM_ARB_TIMEOUT_EN adds a BUSY watchdog.
// Latency: grant/command registered one edge after an eligible request is seen in IDLE with mc_ready.
// Backpressure: grant held until mc_tx_done (or watchdog); mc_ready=0 blocks new grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITCOUNT  = 64,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*2-1:0]               req_op,
    input  logic [NUM_REQ*ADDR_BITCOUNT-1:0]   req_addr,
    input  logic [NUM_REQ*ADDR_BITCOUNT-1:0]   req_offset,
    input  logic [NUM_REQ*WORD_SIZE-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [NUM_REQ-1:0]                 req_err,
    output logic [WORD_SIZE-1:0]               req_rdata,
    output logic [NUM_REQ-1:0]                 req_rd_valid,
    input  logic                               mc_ready,
    output logic [1:0]                         mc_op,
    output logic [ADDR_BITCOUNT-1:0]           mc_raw_address,
    output logic [ADDR_BITCOUNT-1:0]           mc_address_offset,
    output logic [WORD_SIZE-1:0]               mc_wdata,
    input  logic [WORD_SIZE-1:0]               mc_rdata,
    input  logic                               mc_rd_valid,
    input  logic                               mc_tx_done
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_t                 state, state_nxt;
    logic [IDW-1:0]             rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0]         grant_nxt, done_nxt, err_nxt;
    logic [IDW-1:0]             grant_id_nxt;
    mem_op_t                    op_q, op_nxt;
    logic [ADDR_BITCOUNT-1:0]   addr_nxt, off_nxt;
    logic [NUM_REQ-1:0]         eligible, pick_onehot;
    logic [IDW-1:0]             pick_idx;
    logic                       pick_vld;
    logic                       tmo_expire;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && op_is_legal(req_op[i*2 +: 2]);
        end
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (pick_onehot),
        .win_idx  (pick_idx),
        .win_vld  (pick_vld)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;

    // Counter sits at zero outside BUSY so every grant starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || state != ARB_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_expire = (state == ARB_BUSY) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    wire [TW-1:0] unused_tmo_cnt = '0;
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        op_nxt       = op_q;
        addr_nxt     = mc_raw_address;
        off_nxt      = mc_address_offset;
        done_nxt     = '0;
        err_nxt      = '0;
        case (state)
            ARB_IDLE: begin
                if (mc_ready && pick_vld) begin
                    grant_nxt    = pick_onehot;
                    grant_id_nxt = pick_idx;
                    op_nxt       = mem_op_t'(req_op[int'(pick_idx)*2 +: 2]);
                    addr_nxt     = req_addr[int'(pick_idx)*ADDR_BITCOUNT +: ADDR_BITCOUNT];
                    off_nxt      = req_offset[int'(pick_idx)*ADDR_BITCOUNT +: ADDR_BITCOUNT];
                    state_nxt    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mc_tx_done || tmo_expire) begin
                    done_nxt   = grant;
                    err_nxt    = mc_tx_done ? '0 : grant;
                    rr_ptr_nxt = grant_id;
                    grant_nxt  = '0;
                    op_nxt     = OP_IDLE;
                    state_nxt  = ARB_RELEASE;
                end
            end
            // One op=00 cycle lets mem_ctrl drop back to READY before the next command.
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ARB_IDLE;
            rr_ptr            <= IDW'(NUM_REQ - 1);
            grant             <= '0;
            grant_id          <= '0;
            op_q              <= OP_IDLE;
            mc_raw_address    <= '0;
            mc_address_offset <= '0;
            req_done          <= '0;
            req_err           <= '0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            grant             <= grant_nxt;
            grant_id          <= grant_id_nxt;
            op_q              <= op_nxt;
            mc_raw_address    <= addr_nxt;
            mc_address_offset <= off_nxt;
            req_done          <= done_nxt;
            req_err           <= err_nxt;
        end
    end

    assign mc_op        = op_q;
    assign mc_wdata     = req_wdata[int'(grant_id)*WORD_SIZE +: WORD_SIZE];
    assign req_rdata    = mc_rdata;
    assign req_rd_valid = grant & {NUM_REQ{mc_rd_valid}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=32); watchdog vectors
// follow MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int WW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*2-1:0]  req_op;
    logic [N*AW-1:0] req_addr, req_offset;
    logic [N*WW-1:0] req_wdata;
    logic [N-1:0]    grant, req_done, req_err, req_rd_valid;
    logic [1:0]      grant_id;
    logic [WW-1:0]   req_rdata, mc_wdata, mc_rdata;
    logic            mc_ready, mc_rd_valid, mc_tx_done;
    logic [1:0]      mc_op;
    logic [AW-1:0]   mc_raw_address, mc_address_offset;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .ADDR_BITCOUNT(AW), .WORD_SIZE(WW), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_offset(req_offset), .req_wdata(req_wdata),
        .grant(grant), .grant_id(grant_id), .req_done(req_done), .req_err(req_err),
        .req_rdata(req_rdata), .req_rd_valid(req_rd_valid),
        .mc_ready(mc_ready), .mc_op(mc_op), .mc_raw_address(mc_raw_address),
        .mc_address_offset(mc_address_offset), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_rd_valid(mc_rd_valid), .mc_tx_done(mc_tx_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic vld, input logic [1:0] op,
                           input logic [63:0] addr, input logic [63:0] off);
        req_valid[i]          = vld;
        req_op[i*2 +: 2]      = op;
        req_addr[i*AW +: AW]  = addr;
        req_offset[i*AW +: AW] = off;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int cnt;
        cnt = 0;
        while (grant == '0 && cnt < 6) begin
            tick();
            cnt++;
        end
        chk({tag, "_grant_timeout"}, 64'(grant == '0), 64'd0);
    endtask

    task automatic finish_tx();
        mc_tx_done = 1'b1;
        tick();
        mc_tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [WW-1:0] wd2;

        rst = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; req_offset = '0;
        req_wdata = '0; mc_ready = 1'b1; mc_rdata = '0; mc_rd_valid = 1'b0; mc_tx_done = 1'b0;

        // 1: reset values, single read, done/release timing
        do_reset();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_grant_id", 64'(grant_id), 64'h0);
        chk("rst_mc_op", 64'(mc_op), 64'h0);
        chk("rst_done_err", 64'({req_done, req_err}), 64'h0);
        chk("rst_addr", mc_raw_address | mc_address_offset, 64'h0);
        set_req(0, 1'b1, 2'b01, 64'h100, 64'h20);
        tick();
        chk("t1_grant", 64'(grant), 64'b0001);
        chk("t1_mc_op", 64'(mc_op), 64'h1);
        chk("t1_addr", mc_raw_address, 64'h100);
        chk("t1_off", mc_address_offset, 64'h20);
        req_valid = '0;
        set_req(0, 1'b0, 2'b11, 64'h999, 64'h999);
        mc_rd_valid = 1'b1; mc_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_hold_addr", mc_raw_address, 64'h100);
        chk("t1_rd_valid", 64'(req_rd_valid), 64'b0001);
        chk("t1_rdata", 64'(req_rdata), 64'hDEADBEEF);
        mc_rd_valid = 1'b0;
        finish_tx();
        chk("t1_done", 64'(req_done), 64'b0001);
        chk("t1_release_op", 64'(mc_op), 64'h0);
        chk("t1_release_grant", 64'(grant), 64'h0);
        tick();
        chk("t1_done_pulse", 64'(req_done), 64'h0);
        mc_tx_done = 1'b1;
        tick();
        mc_tx_done = 1'b0;
        tick();
        chk("t1_idle_txdone", 64'({req_done, grant}), 64'h0);

        // 2: all four requesters, round-robin order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b01, 64'h1000 + 64'(i), 64'h40 * 64'(i));
        for (int k = 0; k < 5; k++) begin
            wait_grant("t2");
            chk("t2_grant_id", 64'(grant_id), 64'(exp_id[k]));
            chk("t2_grant", 64'(grant), 64'(1) << exp_id[k]);
            chk("t2_addr", mc_raw_address, 64'h1000 + 64'(exp_id[k]));
            for (int c = 0; c < 15; c++) tick();
            finish_tx();
            chk("t2_done", 64'(req_done), 64'(1) << exp_id[k]);
        end
        req_valid = '0;
        tick();

        // 3: write by requester 2, wdata routed every BUSY cycle
        do_reset();
        set_req(2, 1'b1, 2'b11, 64'h2222, 64'h8);
        wait_grant("t3");
        chk("t3_grant_id", 64'(grant_id), 64'd2);
        chk("t3_mc_op", 64'(mc_op), 64'h3);
        for (int c = 0; c < 6; c++) begin
            req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            wd2 = req_wdata[2*WW +: WW];
            #1;
            chk("t3_wdata", 64'(mc_wdata), 64'(wd2));
            chk("t3_rd_valid", 64'(req_rd_valid), 64'h0);
            tick();
        end
        req_valid = '0;
        finish_tx();
        chk("t3_done", 64'(req_done), 64'b0100);
        tick();

        // 4: illegal op never granted; mc_ready low blocks grant
        set_req(1, 1'b1, 2'b10, 64'h3333, 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_illegal", 64'({grant, mc_op}), 64'h0);
        end
        mc_ready = 1'b0;
        set_req(1, 1'b1, 2'b01, 64'h3333, 64'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_not_ready", 64'(grant), 64'h0);
        end
        mc_ready = 1'b1;
        tick();
        chk("t4_ready_grant", 64'(grant), 64'b0010);
        req_valid = '0;
        finish_tx();
        tick();

        // 5: reset in BUSY cycle 5 aborts; requester 0 first afterwards
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b01, 64'h500 + 64'(i), 64'h0);
        wait_grant("t5");
        chk("t5_first", 64'(grant), 64'b0001);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_grant", 64'(grant), 64'h0);
        chk("t5_rst_op", 64'(mc_op), 64'h0);
        chk("t5_rst_done", 64'({req_done, req_err}), 64'h0);
        rst = 1'b0;
        tick();
        chk("t5_regrant", 64'(grant), 64'b0001);
        req_valid = '0;
        finish_tx();
        tick();

        // 6: watchdog
        do_reset();
        set_req(3, 1'b1, 2'b01, 64'h600, 64'h0);
        wait_grant("t6");
        chk("t6_grant", 64'(grant), 64'b1000);
        req_valid = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 31; c++) tick();
        chk("t6_before_expiry", 64'({req_done, grant}), 64'h08);
        tick();
        chk("t6_tmo_done", 64'(req_done), 64'b1000);
        chk("t6_tmo_err", 64'(req_err), 64'b1000);
        chk("t6_tmo_op", 64'(mc_op), 64'h0);
        tick();
        set_req(3, 1'b1, 2'b01, 64'h600, 64'h0);
        wait_grant("t6b");
        req_valid = '0;
        for (int c = 0; c < 31; c++) tick();
        finish_tx();
        chk("t6_race_done", 64'(req_done), 64'b1000);
        chk("t6_race_err", 64'(req_err), 64'h0);
`else
        for (int c = 0; c < 40; c++) tick();
        chk("t6_still_busy", 64'(grant), 64'b1000);
        chk("t6_no_err", 64'({req_done, req_err}), 64'h0);
        finish_tx();
        chk("t6_done", 64'(req_done), 64'b1000);
        chk("t6_err_tied", 64'(req_err), 64'h0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
